// File: rtl/gpr_mp_pkg.sv
// gpr_mp_pkg: shared types, PC source enum and highest-priority write-port select for the multi-port GPR file
package gpr_mp_pkg;
  localparam int MaxWrPorts = 8;
  localparam int SelIdxWidth = $clog2(MaxWrPorts);
  typedef struct packed {
    logic hit;
    logic [SelIdxWidth-1:0] idx;
  } wr_sel_t;
  typedef enum logic [1:0] {PcSeq, PcHold, PcRedir} pc_sel_e;
  function automatic wr_sel_t wr_select(input logic [MaxWrPorts-1:0] match);
    wr_sel_t s;
    s = '0;
    for (int i = 0; i < MaxWrPorts; i++)
      if (match[i]) begin
        s.hit = 1'b1;
        s.idx = SelIdxWidth'(i);
      end
    return s;
  endfunction
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: busy bits per GPR; issue sets, write-back clears, flush wipes; drives issue_ready_o and rs_busy_o
module gpr_scoreboard #(
  parameter int RfAddrWidth = 5,
  parameter int NbGpr = 32,
  parameter int NbReadPorts = 2,
  parameter int NbWritePorts = 2,
  parameter int BypassEn = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic [NbReadPorts*RfAddrWidth-1:0] rs_i,
  output logic [NbReadPorts-1:0] rs_busy_o,
  input  logic issue_valid_i,
  input  logic [RfAddrWidth-1:0] issue_rd_i,
  output logic issue_ready_o,
  input  logic [NbWritePorts-1:0] wr_valid_i,
  input  logic [NbWritePorts*RfAddrWidth-1:0] wr_addr_i,
  input  logic flush_i
);
  logic [NbGpr-1:0] busy_q, clr, set;
  logic rd_ok;
  always_comb begin
    clr = '0;
    for (int j = 0; j < NbWritePorts; j++)
      if (wr_valid_i[j] && wr_addr_i[j*RfAddrWidth +: RfAddrWidth] != '0 &&
          int'(wr_addr_i[j*RfAddrWidth +: RfAddrWidth]) < NbGpr)
        clr[wr_addr_i[j*RfAddrWidth +: RfAddrWidth]] = 1'b1;
    rd_ok = issue_rd_i != '0 && int'(issue_rd_i) < NbGpr;
    issue_ready_o = !rd_ok || !busy_q[issue_rd_i] || clr[issue_rd_i];
    set = '0;
    if (issue_valid_i && issue_ready_o && rd_ok) set[issue_rd_i] = 1'b1;
    rs_busy_o = '0;
    for (int k = 0; k < NbReadPorts; k++)
      rs_busy_o[k] = int'(rs_i[k*RfAddrWidth +: RfAddrWidth]) < NbGpr &&
                     busy_q[rs_i[k*RfAddrWidth +: RfAddrWidth]] &&
                     !(BypassEn != 0 && clr[rs_i[k*RfAddrWidth +: RfAddrWidth]]);
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) busy_q <= '0;
    else busy_q <= flush_i ? '0 : (busy_q & ~clr) | set;
endmodule

// File: rtl/gpr_mp.sv
// gpr_mp: multi-port GPR file + PC; async reads with optional write bypass (rs_*), write-back ports (wr_*), issue scoreboard, PC redirect/stall (pc_*)
module gpr_mp
  import gpr_mp_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int RfAddrWidth = 5,
  parameter int NbGpr = 32,
  parameter int NbReadPorts = 2,
  parameter int NbWritePorts = 2,
  parameter int BypassEn = 1,
  parameter logic [AddrWidth-1:0] StartAddress = '0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic [NbReadPorts*RfAddrWidth-1:0] rs_i,
  output logic [NbReadPorts*DataWidth-1:0] rs_val_o,
  output logic [NbReadPorts-1:0] rs_busy_o,
  input  logic issue_valid_i,
  input  logic [RfAddrWidth-1:0] issue_rd_i,
  output logic issue_ready_o,
  input  logic [NbWritePorts-1:0] wr_valid_i,
  input  logic [NbWritePorts*RfAddrWidth-1:0] wr_addr_i,
  input  logic [NbWritePorts*DataWidth-1:0] wr_data_i,
  input  logic flush_i,
  input  logic [AddrWidth-1:0] pc_next_i,
  input  logic pc_stall_i,
  input  logic pc_redirect_i,
  input  logic [AddrWidth-1:0] pc_redirect_addr_i,
  output logic [AddrWidth-1:0] pc_o
);
  logic [NbGpr-1:0][DataWidth-1:0] regs_q;
  logic [AddrWidth-1:0] pc_q;
  wr_sel_t reg_sel [NbGpr];
  wr_sel_t rd_sel [NbReadPorts];
  pc_sel_e pc_sel;
  function automatic wr_sel_t sel_for(input logic [RfAddrWidth-1:0] a);
    logic [MaxWrPorts-1:0] m;
    m = '0;
    for (int j = 0; j < NbWritePorts; j++)
      m[j] = wr_valid_i[j] && wr_addr_i[j*RfAddrWidth +: RfAddrWidth] == a;
    return (a != '0 && int'(a) < NbGpr) ? wr_select(m) : '0;
  endfunction
  function automatic logic [DataWidth-1:0] wr_word(input wr_sel_t s);
    return wr_data_i[int'(s.idx)*DataWidth +: DataWidth];
  endfunction
  always_comb
    for (int r = 0; r < NbGpr; r++) reg_sel[r] = sel_for(RfAddrWidth'(r));
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) regs_q <= '0;
    else
      for (int r = 1; r < NbGpr; r++)
        if (reg_sel[r].hit) regs_q[r] <= wr_word(reg_sel[r]);
  always_comb begin
    rs_val_o = '0;
    for (int k = 0; k < NbReadPorts; k++) begin
      rd_sel[k] = sel_for(rs_i[k*RfAddrWidth +: RfAddrWidth]);
      rs_val_o[k*DataWidth +: DataWidth] =
        (BypassEn != 0 && rd_sel[k].hit) ? wr_word(rd_sel[k]) :
        int'(rs_i[k*RfAddrWidth +: RfAddrWidth]) < NbGpr ? regs_q[rs_i[k*RfAddrWidth +: RfAddrWidth]] : '0;
    end
  end
  assign pc_sel = pc_redirect_i ? PcRedir : pc_stall_i ? PcHold : PcSeq;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) pc_q <= StartAddress;
    else pc_q <= pc_sel == PcRedir ? pc_redirect_addr_i : pc_sel == PcHold ? pc_q : pc_next_i;
  assign pc_o = pc_q;
  gpr_scoreboard #(
    .RfAddrWidth(RfAddrWidth),
    .NbGpr(NbGpr),
    .NbReadPorts(NbReadPorts),
    .NbWritePorts(NbWritePorts),
    .BypassEn(BypassEn)
  ) u_sb (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .rs_i(rs_i),
    .rs_busy_o(rs_busy_o),
    .issue_valid_i(issue_valid_i),
    .issue_rd_i(issue_rd_i),
    .issue_ready_o(issue_ready_o),
    .wr_valid_i(wr_valid_i),
    .wr_addr_i(wr_addr_i),
    .flush_i(flush_i)
  );
endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: directed vector bench for gpr_mp, bypass and non-bypass instances driven in lockstep
module tb_gpr_mp;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [9:0] rs = '0;
  logic [63:0] val_b, val_n;
  logic [1:0] busy_b, busy_n;
  logic issue_valid = 1'b0;
  logic [4:0] issue_rd = '0;
  logic ready_b, ready_n;
  logic [1:0] wr_valid = '0;
  logic [9:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic flush = 1'b0;
  logic [31:0] pc_next = '0;
  logic pc_stall = 1'b1;
  logic pc_redirect = 1'b0;
  logic [31:0] pc_redirect_addr = '0;
  logic [31:0] pc_b, pc_n;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  gpr_mp #(.BypassEn(1), .StartAddress(32'h1000)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .rs_i(rs), .rs_val_o(val_b), .rs_busy_o(busy_b),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(ready_b),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .flush_i(flush),
    .pc_next_i(pc_next), .pc_stall_i(pc_stall), .pc_redirect_i(pc_redirect),
    .pc_redirect_addr_i(pc_redirect_addr), .pc_o(pc_b));
  gpr_mp #(.BypassEn(0)) dut_n (
    .clk_i(clk), .rstn_i(rstn), .rs_i(rs), .rs_val_o(val_n), .rs_busy_o(busy_n),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(ready_n),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .flush_i(flush),
    .pc_next_i(pc_next), .pc_stall_i(pc_stall), .pc_redirect_i(pc_redirect),
    .pc_redirect_addr_i(pc_redirect_addr), .pc_o(pc_n));
  typedef struct {
    logic [1:0] v;
    logic [4:0] a0, a1;
    logic [31:0] d0, d1;
    logic [4:0] r0, r1;
    logic [31:0] e0, e1, n0, n1;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    vecs[0] = '{2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0};
    vecs[1] = '{2'b00, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[2] = '{2'b11, 7, 7, 32'h11, 32'h22, 7, 5, 32'h22, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[3] = '{2'b00, 0, 0, 0, 0, 7, 0, 32'h22, 0, 32'h22, 0};
    vecs[4] = '{2'b01, 0, 0, 32'hFFFF, 0, 0, 7, 0, 32'h22, 0, 32'h22};
    vecs[5] = '{2'b00, 0, 0, 0, 0, 0, 7, 0, 32'h22, 0, 32'h22};
    vecs[6] = '{2'b11, 7, 9, 32'h33, 32'hAAAA, 9, 7, 32'hAAAA, 32'h33, 0, 32'h22};
    vecs[7] = '{2'b00, 0, 0, 0, 0, 9, 7, 32'hAAAA, 32'h33, 32'hAAAA, 32'h33};
    #1 rstn = 1'b0;
    #2;
    chk("rst_val_b", val_b[31:0] | val_b[63:32], 0);
    chk("rst_val_n", val_n[31:0] | val_n[63:32], 0);
    chk("rst_busy", {30'd0, busy_b | busy_n}, 0);
    chk("rst_pc_b", pc_b, 32'h1000);
    chk("rst_pc_n", pc_n, 0);
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_valid = vecs[i].v;
      wr_addr = {vecs[i].a1, vecs[i].a0};
      wr_data = {vecs[i].d1, vecs[i].d0};
      rs = {vecs[i].r1, vecs[i].r0};
      #1;
      chk($sformatf("v%0d_b0", i), val_b[31:0], vecs[i].e0);
      chk($sformatf("v%0d_b1", i), val_b[63:32], vecs[i].e1);
      chk($sformatf("v%0d_n0", i), val_n[31:0], vecs[i].n0);
      chk($sformatf("v%0d_n1", i), val_n[63:32], vecs[i].n1);
    end
    @(negedge clk);
    wr_valid = '0;
    issue_valid = 1'b1; issue_rd = 3; rs = {5'd0, 5'd3};
    #1 chk("sb_iss3_rdy", {31'd0, ready_b}, 1);
    chk("sb_iss3_free", {30'd0, busy_b}, 0);
    @(negedge clk); #1;
    chk("sb_waw_rdy", {31'd0, ready_b}, 0);
    chk("sb_waw_busy", {30'd0, busy_b}, 2'b01);
    @(negedge clk);
    wr_valid = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'd5};
    #1 chk("sb_wb_rdy", {31'd0, ready_b}, 1);
    chk("sb_wb_mask_b", {30'd0, busy_b}, 0);
    chk("sb_wb_nomask_n", {30'd0, busy_n}, 2'b01);
    chk("sb_wb_byp", val_b[31:0], 5);
    @(negedge clk);
    wr_valid = '0; issue_valid = 1'b0;
    #1 chk("sb_setwins", {30'd0, busy_b}, 2'b01);
    chk("sb_setwins_rdy", {31'd0, ready_b}, 0);
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 0; rs = {5'd0, 5'd0};
    #1 chk("sb_x0_rdy", {31'd0, ready_b}, 1);
    @(negedge clk);
    issue_rd = 1;
    #1 chk("sb_x0_notbusy", {30'd0, busy_b}, 0);
    @(negedge clk);
    issue_rd = 2; rs = {5'd3, 5'd1};
    #1 chk("sb_x1x3_busy", {30'd0, busy_b}, 2'b11);
    @(negedge clk);
    issue_rd = 4; flush = 1'b1; rs = {5'd2, 5'd1};
    #1 chk("sb_fl_rdy", {31'd0, ready_b}, 1);
    chk("sb_x1x2_busy", {30'd0, busy_b}, 2'b11);
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    #1 chk("sb_fl_x1x2", {30'd0, busy_b | busy_n}, 0);
    @(negedge clk);
    rs = {5'd4, 5'd3};
    #1 chk("sb_fl_x3x4", {30'd0, busy_b | busy_n}, 0);
    @(negedge clk);
    pc_stall = 1'b0; pc_next = 32'h200; issue_valid = 1'b1; issue_rd = 5;
    @(negedge clk); #1;
    chk("pc_seq_b", pc_b, 32'h200);
    chk("pc_seq_n", pc_n, 32'h200);
    issue_valid = 1'b0;
    pc_redirect = 1'b1; pc_stall = 1'b1; pc_redirect_addr = 32'h100; pc_next = 32'h300;
    @(negedge clk); #1;
    chk("pc_redir", pc_b, 32'h100);
    pc_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("pc_stall%0d", i), pc_b, 32'h100);
    end
    pc_stall = 1'b0;
    @(negedge clk); #1;
    chk("pc_resume", pc_b, 32'h300);
    rs = {5'd7, 5'd5};
    #1 chk("pre_rst_busy", {30'd0, busy_b}, 2'b01);
    chk("pre_rst_x7", val_b[63:32], 32'h33);
    #1 rstn = 1'b0;
    #1 chk("mid_rst_pc_b", pc_b, 32'h1000);
    chk("mid_rst_pc_n", pc_n, 0);
    chk("mid_rst_busy", {30'd0, busy_b}, 0);
    chk("mid_rst_x7", val_b[63:32], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gpr_mp.md
# gpr_mp

Multi-port general-purpose register file with scoreboard and controlled program counter, the pipelined-core successor of the single-issue GPR file. It holds x0..x(NbGpr-1) plus the PC. It offers NbReadPorts asynchronous read ports with optional same-cycle write bypass and NbWritePorts synchronous write ports. A per-register busy scoreboard tracks in-flight destinations. It sits between decode/issue (reads, issue) and write-back (writes), with the fetch stage consuming `pc_o`.

## Interface
- AddrWidth, 32, PC/address width in bits
- DataWidth, 32, register width (32 or 64)
- RfAddrWidth, 5, register index width
- NbGpr, 32, number of registers, at most 2^RfAddrWidth
- NbReadPorts, 2, number of read ports, at least 1
- NbWritePorts, 2, number of write ports, at least 1
- BypassEn, 1, 1 = forward same-cycle write data to read ports
- StartAddress, '0, PC reset value
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- rs_i  in  NbReadPorts x RfAddrWidth  read addresses
- rs_val_o  out  NbReadPorts x DataWidth  read data
- rs_busy_o  out  NbReadPorts  source register has a pending write
- issue_valid_i  in  1  instruction issuing with a destination
- issue_rd_i  in  RfAddrWidth  destination of the issuing instruction
- issue_ready_o  out  1  issue accepted this cycle (no WAW hazard)
- wr_valid_i  in  NbWritePorts  write-back valid per port
- wr_addr_i  in  NbWritePorts x RfAddrWidth  write-back destination
- wr_data_i  in  NbWritePorts x DataWidth  write-back data
- flush_i  in  1  clear all busy bits (pipeline flush)
- pc_next_i  in  AddrWidth  sequential next PC
- pc_stall_i  in  1  hold PC
- pc_redirect_i  in  1  load redirect target
- pc_redirect_addr_i  in  AddrWidth  redirect target
- pc_o  out  AddrWidth  current PC

## Operation
- Reset (asynchronous, `rstn_i` low): all registers, including x0, go to 0. All busy bits go to 0. `pc_o` = StartAddress. Outputs reflect the reset state immediately.
- x0 always reads 0, is never written, is never busy, and issue to x0 is always ready with no scoreboard effect.
- Writes: on a clock edge, each port with `wr_valid_i` and a non-zero address updates its register. If two ports target the same address, the highest port index wins.
- Reads are combinational. With BypassEn=1, if any valid write port targets `rs_i` this cycle, `rs_val_o` returns that write's data, using the same highest-index priority. With BypassEn=0, reads return the stored value.
- Scoreboard: each write with valid set and a non-zero address clears busy[addr].
- `issue_ready_o` = !busy[issue_rd_i], or issue_rd_i = 0. When a same-cycle write clears the same register, ready is 1.
- An accepted issue (issue_valid_i && issue_ready_o) sets busy[issue_rd_i]. Set wins over a same-cycle clear of the same register.
- `rs_busy_o[k]` = busy[rs_i[k]]. With BypassEn=1 it is masked to 0 when a same-cycle write clears that register.
- `flush_i` clears every busy bit, with priority over a same-cycle issue set. Same-cycle writes still update data.
- PC update priority: redirect > stall > sequential. pc_q <= redirect ? pc_redirect_addr_i : stall ? pc_q : pc_next_i.
- Register indices at or above NbGpr are ignored on write, and reads from them return 0.

## Timing
- Read latency 0 cycles (combinational). Write data is visible from the stored array one cycle after the edge, or in the same cycle through the bypass.
- Busy set/clear takes effect on the next edge. `issue_ready_o` and `rs_busy_o` are combinational.
- PC changes one edge after redirect or next; stall holds it indefinitely.
- Reset assertion mid-operation aborts everything asynchronously. Release is synchronous to the next `clk_i` edge, handled by the system reset synchroniser.

## Structure
- Shared package `gpr_mp_pkg`: function `wr_select` returns the hit flag and index of the highest-priority matching write port (used by writes and bypass).
- Natural sub-module: `gpr_scoreboard` holds the NbGpr busy vector, the issue/write/flush logic, `issue_ready_o` and the read busy flags.

## Test plan
- Reset, then read all ports -> all data 0, `rs_busy_o` = 0, `pc_o` = StartAddress. Assert reset mid-run -> `pc_o` returns to StartAddress without a clock edge.
- Write x5=0xDEADBEEF on port 0 while reading x5 with BypassEn=1 -> `rs_val_o` = 0xDEADBEEF in the same cycle. With BypassEn=0 -> old value, then 0xDEADBEEF next cycle.
- Ports 0 and 1 both write x7 (0x11, 0x22) -> x7 reads 0x22. A write to x0 leaves x0 = 0.
- Issue x3 -> busy; issue x3 again -> `issue_ready_o` = 0. Write-back x3 in the same cycle as a new issue of x3 -> ready = 1, x3 stays busy.
- Set busy on x1, x2, x3, then pulse `flush_i` together with an issue of x4 -> all busy bits 0.
- Assert `pc_redirect_i` and `pc_stall_i` together with target 0x100 -> `pc_o` = 0x100. Stall alone for 3 cycles -> `pc_o` is constant.
